// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a load/store master and data_mem_ctrl.
interface data_mem_ctrl_if #(parameter int ADDR_W = 10);
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable 32-bit word array behind a fixed-latency load/store handshake.
module data_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_req_ready, r_rsp_valid, r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [31:0]       r_mem [DEPTH];
    logic              w_acc, w_err;
    logic [1:0]        w_off;
    logic [ADDR_W-3:0] w_widx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_word, w_load;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    assign w_off  = bus.req_addr[1:0];
    assign w_widx = bus.req_addr[ADDR_W-1:2];
    assign w_acc  = rst && r_state == IDLE && bus.req_valid;
    assign w_err  = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && w_off[0])
                 || (bus.req_size == 2'b10 && w_off != 2'b00);
    assign w_be   = bus.req_size == 2'b00 ? 4'b0001 << w_off
                  : bus.req_size == 2'b01 ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // Replicate narrow store data across lanes so the byte enables pick the right copy
    assign w_wdata = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}}
                   : bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    assign w_word = r_mem[w_widx];
    assign w_byte = w_word[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    assign w_load = bus.req_size == 2'b00 ? {{24{~bus.req_unsigned & w_byte[7]}}, w_byte}
                  : bus.req_size == 2'b01 ? {{16{~bus.req_unsigned & w_half[15]}}, w_half} : w_word;
    always_ff @(posedge clk)
        if (w_acc && bus.req_we && !w_err)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_req_ready <= 1'b0;
                    r_rsp_err   <= w_err;
                    r_rsp_rdata <= (w_err || bus.req_we) ? 32'd0 : w_load;
                    if (LATENCY == 1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule
